central_processing_unit: RTL and testbench

- Single-cycle RV32I integer core: fetches one instruction per clock from an external instruction source addressed by `program_counter`, executes it, and retires it at the rising clock edge.
- Connects to a simple single-port data memory: combinational address, read data and write data, with a write strobe.
- Top-level compute block of the computer; instruction ROM and data RAM are external.

---
 rtl/central_processing_unit.sv | 169 ++++++++++++++++
 tb/tb_central_processing_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/central_processing_unit.sv
// Single-cycle RV32I core: one instruction fetched, executed and retired per clock.
// Instruction ROM and data RAM are external and combinational.
module central_processing_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [31:0] program_counter,
    output logic        memory_write_en,
    output logic [31:0] memory_address,
    input  logic [31:0] memory_read_value,
    output logic [31:0] memory_write_value
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] regs [32];
    logic [31:0] rs1_value, rs2_value, pc_plus4;
    logic        is_store;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    assign rs1_value = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_value = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign pc_plus4  = program_counter + 32'd4;

    // Address is always driven (I or S offset) so loads and JALR share the adder.
    assign is_store        = (opcode == OPC_STORE);
    assign memory_address  = rs1_value + (is_store ? imm_s : imm_i);
    assign memory_write_en = !reset && is_store && !funct3[2] && (funct3[1:0] != 2'b11);

    always_comb begin
        memory_write_value = rs2_value;
        if (is_store && funct3 == 3'b000) memory_write_value = {24'd0, rs2_value[7:0]};
        if (is_store && funct3 == 3'b001) memory_write_value = {16'd0, rs2_value[15:0]};
    end

    logic [31:0] operand_b, alu_result;
    logic        alt, alu_legal;

    always_comb begin
        operand_b  = (opcode == OPC_OP) ? rs2_value : imm_i;
        alt        = 1'b0;
        alu_legal  = 1'b1;
        alu_result = 32'd0;
        if (opcode == OPC_OP) begin
            alt       = funct7[5];
            alu_legal = (funct7 == 7'd0) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        end else begin
            alt = (funct3 == 3'b101) && funct7[5];
            if (funct3 == 3'b001) alu_legal = (funct7 == 7'd0);
            if (funct3 == 3'b101) alu_legal = (funct7 == 7'd0) || (funct7 == 7'b0100000);
        end
        case (funct3)
            3'b000:  alu_result = alt ? rs1_value - operand_b : rs1_value + operand_b;
            3'b001:  alu_result = rs1_value << operand_b[4:0];
            3'b010:  alu_result = {31'd0, $signed(rs1_value) < $signed(operand_b)};
            3'b011:  alu_result = {31'd0, rs1_value < operand_b};
            3'b100:  alu_result = rs1_value ^ operand_b;
            3'b101:  alu_result = alt ? 32'($signed(rs1_value) >>> operand_b[4:0])
                                      : rs1_value >> operand_b[4:0];
            3'b110:  alu_result = rs1_value | operand_b;
            default: alu_result = rs1_value & operand_b;
        endcase
    end

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic        load_legal;

    always_comb begin
        case (memory_address[1:0])
            2'd0:    load_byte = memory_read_value[7:0];
            2'd1:    load_byte = memory_read_value[15:8];
            2'd2:    load_byte = memory_read_value[23:16];
            default: load_byte = memory_read_value[31:24];
        endcase
        load_half  = memory_address[1] ? memory_read_value[31:16] : memory_read_value[15:0];
        load_legal = 1'b1;
        case (funct3)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b010:  load_value = memory_read_value;
            3'b100:  load_value = {24'd0, load_byte};
            3'b101:  load_value = {16'd0, load_half};
            default: begin load_value = 32'd0; load_legal = 1'b0; end
        endcase
    end

    logic branch_taken;

    always_comb begin
        case (funct3)
            3'b000:  branch_taken = (rs1_value == rs2_value);
            3'b001:  branch_taken = (rs1_value != rs2_value);
            3'b100:  branch_taken = ($signed(rs1_value) <  $signed(rs2_value));
            3'b101:  branch_taken = ($signed(rs1_value) >= $signed(rs2_value));
            3'b110:  branch_taken = (rs1_value <  rs2_value);
            3'b111:  branch_taken = (rs1_value >= rs2_value);
            default: branch_taken = 1'b0;
        endcase
    end

    logic [31:0] next_pc, rd_value;
    logic        rd_write;

    // Anything not decoded below (FENCE, SYSTEM, illegal encodings) just falls through to PC+4.
    always_comb begin
        next_pc  = pc_plus4;
        rd_write = 1'b0;
        rd_value = 32'd0;
        case (opcode)
            OPC_LUI:    begin rd_write = 1'b1; rd_value = imm_u; end
            OPC_AUIPC:  begin rd_write = 1'b1; rd_value = program_counter + imm_u; end
            OPC_JAL: begin
                rd_write = 1'b1;
                rd_value = pc_plus4;
                next_pc  = program_counter + imm_j;
            end
            OPC_JALR: if (funct3 == 3'b000) begin
                rd_write = 1'b1;
                rd_value = pc_plus4;
                next_pc  = memory_address & ~32'd1;
            end
            OPC_BRANCH: if (branch_taken) next_pc = program_counter + imm_b;
            OPC_LOAD:   begin rd_write = load_legal; rd_value = load_value; end
            OPC_OPIMM,
            OPC_OP:     begin rd_write = alu_legal; rd_value = alu_result; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            program_counter <= RESET_PC;
            for (int k = 0; k < 32; k++) regs[k] <= 32'd0;
        end else begin
            program_counter <= next_pc;
            if (rd_write && rd != 5'd0) regs[rd] <= rd_value;
        end
    end
endmodule

// File: tb/tb_central_processing_unit.sv
// Directed bench for central_processing_unit; register contents are observed through
// memory_address by issuing "ADDI x0, rN, 0" probes, which change no state.
module tb_central_processing_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] program_counter;
    logic        memory_write_en;
    logic [31:0] memory_address;
    logic [31:0] memory_read_value;
    logic [31:0] memory_write_value;

    central_processing_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock              (clock),
        .reset              (reset),
        .instruction        (instruction),
        .program_counter    (program_counter),
        .memory_write_en    (memory_write_en),
        .memory_address     (memory_address),
        .memory_read_value  (memory_read_value),
        .memory_write_value (memory_write_value)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] pc_m;

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] v, a, f, d, o;
        v = imm; a = rs1; f = f3; d = rd; o = op;
        return {v[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input int imm, input int rs1, input int rs2, input int f3);
        logic [31:0] v, b, a, f;
        v = imm; b = rs2; a = rs1; f = f3;
        return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] u_t(input int imm20, input int rd, input int op);
        logic [31:0] v, d, o;
        v = imm20; d = rd; o = op;
        return {v[19:0], d[4:0], o[6:0]};
    endfunction
    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
    endfunction
    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction

    localparam int OPIMM = 7'b0010011;
    localparam int LOAD  = 7'b0000011;

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Non-store instruction: strobe must stay low, then PC must land on npc.
    task automatic run(input logic [31:0] ins, input logic [31:0] npc);
        instruction = ins;
        #1;
        exp_q.push_back(32'd0);
        chk("we_low", {31'd0, memory_write_en});
        @(posedge clock); #1;
        pc_m = npc;
        exp_q.push_back(npc);
        chk("pc", program_counter);
    endtask

    task automatic seq(input logic [31:0] ins);
        run(ins, pc_m + 32'd4);
    endtask

    task automatic store(input logic [31:0] ins, input logic [31:0] addr, input logic [31:0] wval);
        instruction = ins;
        #1;
        exp_q.push_back(32'd1);  chk("st_we", {31'd0, memory_write_en});
        exp_q.push_back(addr);   chk("st_addr", memory_address);
        exp_q.push_back(wval);   chk("st_wval", memory_write_value);
        @(posedge clock); #1;
        pc_m = pc_m + 32'd4;
        exp_q.push_back(pc_m);
        chk("pc", program_counter);
    endtask

    task automatic probe(input int r, input logic [31:0] v, input string tag);
        instruction = i_t(0, r, 0, 0, OPIMM);
        #1;
        exp_q.push_back(v);
        chk(tag, memory_address);
    endtask

    initial begin
        reset = 1'b1;
        memory_read_value = 32'd0;
        instruction = s_t(0, 1, 0, 2);
        #1;
        exp_q.push_back(32'd0);
        chk("reset_we", {31'd0, memory_write_en});
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        pc_m = 32'd0;
        exp_q.push_back(32'd0);
        chk("reset_pc", program_counter);

        // Arithmetic chain
        seq(i_t(5, 0, 0, 1, OPIMM));
        seq(i_t(-7, 1, 0, 2, OPIMM));
        seq(r_t(0, 2, 1, 0, 3));
        probe(3, 32'd3, "add_x3");
        probe(2, 32'hFFFF_FFFE, "addi_neg_x2");

        // Stores: word, byte and half with zero-extension
        store(s_t(8, 1, 0, 2), 32'h8, 32'h5);
        store(s_t(3, 2, 1, 0), 32'h8, 32'h0000_00FE);
        store(s_t(-1, 2, 1, 1), 32'h4, 32'h0000_FFFE);
        seq(i_t(0, 0, 0, 0, OPIMM));

        // Loads and byte/half lane selection
        memory_read_value = 32'h0000_0005;
        seq(i_t(0, 0, 2, 4, LOAD));
        probe(4, 32'd5, "lw");
        memory_read_value = 32'h0000_80FF;
        seq(i_t(0, 0, 0, 5, LOAD));
        seq(i_t(0, 0, 4, 6, LOAD));
        seq(i_t(0, 0, 1, 7, LOAD));
        seq(i_t(0, 0, 5, 8, LOAD));
        probe(5, 32'hFFFF_FFFF, "lb");
        probe(6, 32'h0000_00FF, "lbu");
        probe(7, 32'hFFFF_80FF, "lh");
        probe(8, 32'h0000_80FF, "lhu");
        memory_read_value = 32'h12AB_0000;
        seq(i_t(2, 0, 4, 9, LOAD));
        seq(i_t(2, 0, 1, 10, LOAD));
        seq(i_t(3, 0, 0, 11, LOAD));
        probe(9, 32'h0000_00AB, "lbu_off2");
        probe(10, 32'h0000_12AB, "lh_upper");
        probe(11, 32'h0000_0012, "lb_off3");

        // Branches and jumps
        run(j_t(32'h20 - pc_m, 0), 32'h20);
        run(b_t(16, 1, 1, 1), 32'h24);
        run(j_t(-4, 0), 32'h20);
        run(b_t(16, 1, 1, 0), 32'h30);
        run(b_t(8, 2, 1, 4), 32'h38);
        run(b_t(8, 2, 1, 6), 32'h3C);
        run(b_t(4, 2, 1, 7), 32'h40);
        run(j_t(-8, 1), 32'h38);
        probe(1, 32'h44, "jal_link");
        seq(i_t(32'h100, 0, 0, 1, OPIMM));
        run(i_t(1, 1, 0, 0, 7'b1100111), 32'h100);
        run(i_t(32'h20, 1, 0, 1, 7'b1100111), 32'h120);
        probe(1, 32'h104, "jalr_rd_eq_rs1");

        // Upper immediates, shifts, compares
        run(j_t(32'h10 - 32'h120, 0), 32'h10);
        seq(u_t(1, 6, 7'b0010111));
        probe(6, 32'h0000_1010, "auipc");
        seq(u_t(32'h12345, 5, 7'b0110111));
        probe(5, 32'h1234_5000, "lui");
        seq(u_t(32'h80000, 7, 7'b0110111));
        seq(i_t(32'h404, 7, 5, 8, OPIMM));
        seq(i_t(4, 7, 5, 9, OPIMM));
        probe(8, 32'hF800_0000, "srai");
        probe(9, 32'h0800_0000, "srli");
        seq(i_t(1, 0, 0, 10, OPIMM));
        seq(i_t(-1, 0, 0, 11, OPIMM));
        seq(r_t(0, 11, 10, 3, 12));
        seq(r_t(0, 11, 10, 2, 13));
        seq(r_t(32, 11, 10, 0, 14));
        seq(r_t(0, 11, 10, 1, 15));
        seq(r_t(32, 10, 8, 5, 16));
        probe(12, 32'd1, "sltu");
        probe(13, 32'd0, "slt");
        probe(14, 32'd2, "sub");
        probe(15, 32'h8000_0000, "sll_amt31");
        probe(16, 32'hFC00_0000, "sra_reg");
        seq(i_t(9, 0, 0, 0, OPIMM));
        probe(0, 32'd0, "x0_const");
        seq(32'hFFFF_FFFF);
        probe(5, 32'h1234_5000, "illegal_noop");

        // Reset during a store
        instruction = s_t(0, 5, 0, 2);
        reset = 1'b1;
        #1;
        exp_q.push_back(32'd0);
        chk("reset_st_we", {31'd0, memory_write_en});
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.push_back(32'd0);
        chk("reset_pc2", program_counter);
        for (int r = 0; r < 32; r++) probe(r, 32'd0, "reset_reg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
